// File: rtl/imem_loader.sv
// imem_loader: boot-time byte-stream loader that fills instruction memory and
// holds the CPU in reset until the image checksum verifies.
module imem_loader #(
    parameter int SIZE = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_reset,
    output logic        done,
    output logic        error
);
    typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_WRITE, S_CSUM, S_DONE, S_ERROR} state_t;
    state_t      r_state, w_next;
    logic [1:0]  r_bcnt;
    logic [31:0] r_len, r_cnt, r_asm, r_addr, r_wdata;
    logic [7:0]  r_csum;
    logic        w_acc, w_last;
    logic [31:0] w_word, w_cnt_inc;
    assign w_acc      = byte_valid && byte_ready;
    assign w_last     = r_bcnt == 2'd3;
    assign w_word     = {r_asm[23:0], byte_in};
    assign w_cnt_inc  = r_cnt + 32'd1;
    assign byte_ready = r_state == S_LEN || r_state == S_DATA || r_state == S_CSUM;
    assign mem_we     = r_state == S_WRITE;
    assign done       = r_state == S_DONE;
    assign error      = r_state == S_ERROR;
    assign cpu_reset  = !done;
    assign mem_addr   = r_addr;
    assign mem_wdata  = r_wdata;
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = S_LEN;
            S_LEN:   if (w_acc && w_last)
                         w_next = w_word == 32'd0 ? S_CSUM : w_word > 32'(SIZE) ? S_ERROR : S_DATA;
            S_DATA:  if (w_acc && w_last) w_next = S_WRITE;
            S_WRITE: w_next = w_cnt_inc == r_len ? S_CSUM : S_DATA;
            S_CSUM:  if (w_acc) w_next = byte_in == r_csum ? S_DONE : S_ERROR;
            default: w_next = r_state;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_bcnt  <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_asm   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_csum  <= '0;
        end else begin
            r_state <= w_next;
            if (w_acc) begin
                r_bcnt <= r_bcnt + 2'd1;
                r_asm  <= w_word;
            end
            if (w_acc && r_state == S_LEN && w_last) r_len <= w_word;
            if (w_acc && r_state == S_DATA) begin
                r_csum <= r_csum ^ byte_in;
                if (w_last) r_wdata <= w_word;
            end
            // address only advances when another word follows, so it never passes the last slot
            if (r_state == S_WRITE) begin
                r_cnt <= w_cnt_inc;
                if (w_cnt_inc != r_len) r_addr <= r_addr + 32'd4;
            end
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed self-checking bench for imem_loader.
module tb_imem_loader;
    logic        clk = 0, reset = 1;
    logic [7:0]  byte_in = 0;
    logic        byte_valid = 0;
    logic        byte_ready, mem_we, cpu_reset, done, error;
    logic [31:0] mem_addr, mem_wdata;
    int n_chk = 0, n_fail = 0;
    logic [31:0] wa[$], wd[$];
    logic [7:0]  q_tx[$];

    imem_loader #(.SIZE(1024)) dut (
        .clk(clk), .reset(reset), .byte_in(byte_in), .byte_valid(byte_valid),
        .byte_ready(byte_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .cpu_reset(cpu_reset), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (mem_we) begin
                wa.push_back(mem_addr);
                wd.push_back(mem_wdata);
                chk("ready_in_write", {31'd0, byte_ready}, 32'd0);
            end
            chk("cpu_reset_not_done", {31'd0, cpu_reset}, {31'd0, !done});
            chk("done_and_error", {31'd0, done && error}, 32'd0);
        end
    end

    task automatic do_reset();
        byte_valid = 0;
        reset = 1;
        repeat (2) @(negedge clk);
        wa.delete();
        wd.delete();
        reset = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gapped);
        int t = 0;
        bit acc = 0, prev_write = 0;
        while (!acc && t < 50) begin
            @(negedge clk);
            if (prev_write) chk("ready_after_write", {31'd0, byte_ready}, 32'd1);
            if (gapped && $urandom_range(0, 1) == 1) byte_valid = 0;
            else begin
                byte_valid = 1;
                byte_in = b;
            end
            acc = byte_valid && byte_ready;
            prev_write = byte_valid && mem_we;
            @(posedge clk);
            t++;
        end
        chk("byte_accept", {31'd0, acc}, 32'd1);
    endtask

    task automatic send_all(input bit gapped);
        foreach (q_tx[i]) send_byte(q_tx[i], gapped);
        @(negedge clk);
        byte_valid = 0;
    endtask

    task automatic load_nominal(input logic [7:0] cs);
        // XOR of the eight data bytes is 0x55
        q_tx = '{8'h00, 8'h00, 8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
                 8'h01, 8'h09, 8'h50, 8'h20, cs};
    endtask

    task automatic check_writes();
        chk("write_count", wa.size(), 32'd2);
        if (wa.size() == 2) begin
            chk("addr0", wa[0], 32'h0);
            chk("data0", wd[0], 32'h20080005);
            chk("addr1", wa[1], 32'h4);
            chk("data1", wd[1], 32'h01095020);
        end
    endtask

    task automatic check_good();
        check_writes();
        chk("done", {31'd0, done}, 32'd1);
        chk("cpu_reset", {31'd0, cpu_reset}, 32'd0);
        chk("byte_ready", {31'd0, byte_ready}, 32'd0);
        chk("error", {31'd0, error}, 32'd0);
        chk("wdata_hold", mem_wdata, 32'h01095020);
    endtask

    initial begin
        #12;
        chk("rst_ready", {31'd0, byte_ready}, 32'd0);
        chk("rst_we", {31'd0, mem_we}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_error", {31'd0, error}, 32'd0);

        do_reset();
        load_nominal(8'h55);
        send_all(0);
        check_good();

        do_reset();
        q_tx = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_all(0);
        chk("zero_writes", wa.size(), 32'd0);
        chk("zero_done", {31'd0, done}, 32'd1);

        do_reset();
        q_tx = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hFF};
        send_all(0);
        chk("zero_bad_error", {31'd0, error}, 32'd1);
        chk("zero_bad_cpu_reset", {31'd0, cpu_reset}, 32'd1);

        do_reset();
        q_tx = '{8'h00, 8'h00, 8'h04, 8'h01};
        send_all(0);
        chk("over_error", {31'd0, error}, 32'd1);
        byte_valid = 1;
        byte_in = 8'hAA;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("over_no_accept", {31'd0, byte_ready}, 32'd0);
        end
        byte_valid = 0;
        chk("over_writes", wa.size(), 32'd0);
        chk("over_error_sticky", {31'd0, error}, 32'd1);

        do_reset();
        load_nominal(8'h45);
        send_all(0);
        check_writes();
        chk("bad_error", {31'd0, error}, 32'd1);
        chk("bad_done", {31'd0, done}, 32'd0);
        chk("bad_cpu_reset", {31'd0, cpu_reset}, 32'd1);

        do_reset();
        load_nominal(8'h55);
        send_all(1);
        check_good();

        do_reset();
        load_nominal(8'h55);
        for (int i = 0; i < 6; i++) send_byte(q_tx[i], 0);
        #3 reset = 1;
        #1;
        chk("mid_ready", {31'd0, byte_ready}, 32'd0);
        chk("mid_we", {31'd0, mem_we}, 32'd0);
        chk("mid_addr", mem_addr, 32'd0);
        chk("mid_wdata", mem_wdata, 32'd0);
        chk("mid_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        chk("mid_done", {31'd0, done}, 32'd0);
        chk("mid_error", {31'd0, error}, 32'd0);
        do_reset();
        send_all(0);
        check_good();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
